// File: rtl/dfm_pkg.sv
// rtl/dfm_pkg.sv - shared state encodings and default parameters for multi_channel_measure
package dfm_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_t;

    typedef enum logic [1:0] {
        CH_ARM   = 2'd0,
        CH_COUNT = 2'd1,
        CH_DONE  = 2'd2
    } ch_state_t;

    localparam int DFM_CH_NUM      = 4;
    localparam int DFM_CNT_WIDTH   = 32;
    localparam int DFM_GATE_CYCLES = 12000000;

endpackage

// File: rtl/multi_channel_measure_if.sv
// rtl/multi_channel_measure_if.sv - sequencer <-> channel control and result bundle
interface multi_channel_measure_if #(
    parameter int CNT_WIDTH = dfm_pkg::DFM_CNT_WIDTH
);
    logic                 clear;
    logic                 gate_done;
    logic                 done;
    logic [CNT_WIDTH-1:0] sig_cnt;
    logic [CNT_WIDTH-1:0] ref_cnt;

    modport master (output clear, output gate_done, input done, input sig_cnt, input ref_cnt);
    modport slave  (input clear, input gate_done, output done, output sig_cnt, output ref_cnt);
endinterface

// File: rtl/dfm_channel.sv
// rtl/dfm_channel.sv - one measurement channel: synchronizer, rising-edge detector,
// ARM/COUNT/DONE sequencing and saturating reference/signal counters
module dfm_channel
    import dfm_pkg::*;
#(
    parameter int CNT_WIDTH = DFM_CNT_WIDTH
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_sig,
    multi_channel_measure_if.slave  ch
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [1:0]           r_sync;
    logic                 r_sync_d;
    logic                 r_edge;
    ch_state_t            r_state;
    ch_state_t            w_next;
    logic [CNT_WIDTH-1:0] r_sig_cnt;
    logic [CNT_WIDTH-1:0] r_ref_cnt;

    // Registered edge so the pulse is visible three clocks after the input rise
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync   <= '0;
            r_sync_d <= 1'b0;
            r_edge   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], i_sig};
            r_sync_d <= r_sync[1];
            r_edge   <= r_sync[1] & ~r_sync_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CH_ARM;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (ch.clear) begin
            w_next = CH_ARM;
        end else begin
            case (r_state)
                CH_ARM:   if (r_edge) w_next = CH_COUNT;
                CH_COUNT: if (r_edge && ch.gate_done) w_next = CH_DONE;
                CH_DONE:  w_next = CH_DONE;
                default:  w_next = CH_ARM;
            endcase
        end
    end

    // The closing edge is counted in both counters on its way to DONE
    always_ff @(posedge i_clk) begin
        if (i_rst || ch.clear) begin
            r_sig_cnt <= '0;
            r_ref_cnt <= '0;
        end else if (r_state == CH_COUNT) begin
            if (r_ref_cnt != CNT_MAX) begin
                r_ref_cnt <= r_ref_cnt + CNT_WIDTH'(1);
            end
            if (r_edge && (r_sig_cnt != CNT_MAX)) begin
                r_sig_cnt <= r_sig_cnt + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        ch.done    = (r_state == CH_DONE);
        ch.sig_cnt = r_sig_cnt;
        ch.ref_cnt = r_ref_cnt;
    end

endmodule

// File: rtl/multi_channel_measure.sv
// rtl/multi_channel_measure.sv - multi-channel period/frequency measurement with drain to result writes;
// define DFM_TIMEOUT_EN to bound RUN at 2*GATE_CYCLES cycles
module multi_channel_measure
    import dfm_pkg::*;
#(
    parameter int  CH_NUM      = DFM_CH_NUM,
    parameter int  CNT_WIDTH   = DFM_CNT_WIDTH,
    parameter int  GATE_CYCLES = DFM_GATE_CYCLES,
    localparam int CH_W        = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [CH_NUM-1:0]      sig_clk_i,
    input  logic                   start_i,
    input  logic                   cont_i,
    output logic                   busy_o,
    output logic                   reg_wr_en_o,
    output logic [CH_W-1:0]        reg_wr_ch_o,
    output logic [2*CNT_WIDTH-1:0] reg_wr_data_o
);
    localparam int            GW        = $clog2(2 * GATE_CYCLES) + 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [GW-1:0] RUN_LAST  = GW'(2 * GATE_CYCLES - 1);
    localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH_NUM - 1);

    seq_state_t             r_state;
    seq_state_t             w_next;
    logic [GW-1:0]          r_gate_cnt;
    logic [CH_W-1:0]        r_drain_ch;
    logic                   w_run_entry;
    logic                   w_gate_done;
    logic                   w_all_done;
    logic                   w_timeout;
    logic [CH_NUM-1:0]      w_done;
    logic [CNT_WIDTH-1:0]   w_sig_cnt [CH_NUM];
    logic [CNT_WIDTH-1:0]   w_ref_cnt [CH_NUM];
    logic [2*CNT_WIDTH-1:0] w_drain_data;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            SEQ_IDLE:  if (start_i || cont_i) w_next = SEQ_RUN;
            SEQ_RUN:   if (w_all_done || w_timeout) w_next = SEQ_DRAIN;
            SEQ_DRAIN: if (r_drain_ch == CH_LAST) w_next = cont_i ? SEQ_RUN : SEQ_IDLE;
            default:   w_next = SEQ_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (r_state != SEQ_IDLE);
        reg_wr_en_o   = 1'b0;
        reg_wr_ch_o   = '0;
        reg_wr_data_o = '0;
        if (r_state == SEQ_DRAIN) begin
            reg_wr_en_o   = 1'b1;
            reg_wr_ch_o   = r_drain_ch;
            reg_wr_data_o = w_drain_data;
        end
    end

    assign w_run_entry = (r_state != SEQ_RUN) && (w_next == SEQ_RUN);
    assign w_gate_done = (r_state == SEQ_RUN) && (r_gate_cnt >= GATE_LAST);
    assign w_all_done  = &w_done;

    // Gate counter parks at RUN_LAST so gate_done stays up for as long as RUN lasts
    always_ff @(posedge clk_i) begin
        if (rst_i || w_run_entry) begin
            r_gate_cnt <= '0;
        end else if ((r_state == SEQ_RUN) && (r_gate_cnt != RUN_LAST)) begin
            r_gate_cnt <= r_gate_cnt + GW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state != SEQ_DRAIN)) begin
            r_drain_ch <= '0;
        end else begin
            r_drain_ch <= r_drain_ch + CH_W'(1);
        end
    end

`ifdef DFM_TIMEOUT_EN
    assign w_timeout    = (r_state == SEQ_RUN) && (r_gate_cnt == RUN_LAST);
    assign w_drain_data = w_done[r_drain_ch] ?
                          {w_sig_cnt[r_drain_ch], w_ref_cnt[r_drain_ch]} : '0;
`else
    assign w_timeout    = 1'b0;
    assign w_drain_data = {w_sig_cnt[r_drain_ch], w_ref_cnt[r_drain_ch]};
`endif

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        multi_channel_measure_if #(.CNT_WIDTH(CNT_WIDTH)) u_if ();

        assign u_if.clear     = w_run_entry;
        assign u_if.gate_done = w_gate_done;
        assign w_done[g]      = u_if.done;
        assign w_sig_cnt[g]   = u_if.sig_cnt;
        assign w_ref_cnt[g]   = u_if.ref_cnt;

        dfm_channel #(.CNT_WIDTH(CNT_WIDTH)) u_ch (
            .i_clk (clk_i),
            .i_rst (rst_i),
            .i_sig (sig_clk_i[g]),
            .ch    (u_if.slave)
        );
    end

endmodule

// File: doc/multi_channel_measure.md
MULTI_CHANNEL_MEASURE -- requirements
Module: multi_channel_measure

Interface
REQ-001 SHALL have parameter CH_NUM, default 4: number of independent input channels (1..16).
REQ-002 SHALL have parameter CNT_WIDTH, default 32: width of each reference and signal counter.
REQ-003 SHALL have parameter GATE_CYCLES, default 12000000: minimum gate length in clk_i cycles (1 s at 12 MHz).
REQ-004 SHALL have port clk_i  input  1  system clock; single clock domain.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port sig_clk_i  input  CH_NUM  asynchronous signals under measurement, one bit per channel.
REQ-007 SHALL have port start_i  input  1  single-cycle pulse requesting one measurement round.
REQ-008 SHALL have port cont_i  input  1  continuous mode: start a new round automatically after each drain.
REQ-009 SHALL have port busy_o  output  1  high while a round is running or draining.
REQ-010 SHALL have port reg_wr_en_o  output  1  result write strobe, one cycle per channel.
REQ-011 SHALL have port reg_wr_ch_o  output  $clog2(CH_NUM) (min 1)  channel index of the current write.
REQ-012 SHALL have port reg_wr_data_o  output  2*CNT_WIDTH  result {sig_cnt, ref_cnt}.

Function
REQ-013 Each sig_clk_i bit SHALL pass a 2-flop synchronizer plus rising-edge detector; an edge SHALL appear 3 cycles after the input rise.
REQ-014 Sequencer states SHALL be IDLE, RUN, DRAIN; IDLE->RUN on start_i or (cont_i while in IDLE).
REQ-015 On RUN entry, the shared gate counter SHALL clear, count every cycle, and assert gate_done once it reaches GATE_CYCLES-1; gate_done holds until RUN exits.
REQ-016 Per-channel states SHALL be ARM, COUNT, DONE; all channels SHALL enter ARM on RUN entry with counters cleared.
REQ-017 ARM->COUNT on the first detected edge (opening edge); that edge is not counted.
REQ-018 In COUNT, ref_cnt SHALL increment every cycle and sig_cnt on every detected edge; the first edge with gate_done high (closing edge) SHALL be counted in both, then COUNT->DONE.
REQ-019 Result: signal period P cycles measured over k periods SHALL yield sig_cnt=k, ref_cnt=k*P exactly.
REQ-020 Counters SHALL saturate at all-ones, never wrap.
REQ-021 RUN->DRAIN when all channels are DONE; DRAIN SHALL write channels 0..CH_NUM-1 on consecutive cycles, reg_wr_en_o high for exactly CH_NUM cycles.
REQ-022 DRAIN->RUN in the cycle after the last write if cont_i is high, else DRAIN->IDLE.
REQ-023 start_i SHALL be ignored while busy_o is high.
REQ-024 busy_o SHALL be high in RUN and DRAIN, low in IDLE.

Reset
REQ-025 rst_i SHALL force IDLE, all channels ARM, all counters 0, busy_o=0, reg_wr_en_o=0, reg_wr_ch_o=0, reg_wr_data_o=0, synchronizer flops 0.
REQ-026 rst_i asserted mid-RUN or mid-DRAIN SHALL abort the round with no further writes.

Configuration
REQ-027 With DFM_TIMEOUT_EN defined, RUN SHALL end after 2*GATE_CYCLES cycles regardless of channel state; any channel not DONE SHALL report all-zero result.
REQ-028 Without DFM_TIMEOUT_EN, RUN SHALL wait indefinitely for all channels to reach DONE (exit only by reset).

Structure
REQ-029 Package dfm_pkg SHALL hold the sequencer state enum, channel state enum and default parameter constants.
REQ-030 Per-channel synchronizer, edge detector, ARM/COUNT/DONE FSM and counters SHALL be sub-module dfm_channel, instantiated CH_NUM times via generate.

Verification (CH_NUM=2, CNT_WIDTH=16, GATE_CYCLES=100)
REQ-031 Ch0 period 10, ch1 period 25, start_i pulse -> two writes, ch0 then ch1; ch0 ref=10*sig, sig 10 or 11; ch1 ref=25*sig, sig 4 or 5.
REQ-032 cont_i=1, ch0 period 10 -> back-to-back rounds, writes every round, busy_o never drops.
REQ-033 Ch1 held low, DFM_TIMEOUT_EN defined -> writes at cycle ~200 after start; ch1 data 0, ch0 valid.
REQ-034 CNT_WIDTH=8, GATE_CYCLES=300, period 20 -> ref_cnt=255 saturated, no wrap.
REQ-035 rst_i pulsed mid-RUN -> busy_o=0 next cycle, no reg_wr_en_o until a new start_i.
REQ-036 start_i pulsed during RUN -> ignored; exactly CH_NUM writes for the round.
